// File: rtl/arm_pkg.sv
// Shared types and constants for the LDM/STM multi-register transfer sequencer.
package arm_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned REG_PC     = 15;
    localparam int unsigned LIST_W     = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_WB,
        ST_DONE
    } seq_state_t;

    // Encoding is {P, U} so the mode falls straight out of the instruction bits.
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } addr_mode_t;

    typedef struct packed {
        logic             is_load;
        logic             wb_en;
        logic             has_pc;
        logic [REG_W-1:0] base_reg;
    } xfer_ctx_t;

    function automatic addr_mode_t decode_mode(input logic pre, input logic up);
        return addr_mode_t'({pre, up});
    endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// 16-bit priority encoder: index of the lowest set bit plus a valid flag.
module lowest_set_bit
    import arm_pkg::*;
(
    input  logic [LIST_W-1:0] bits,
    output logic [IDX_W-1:0]  idx_c,
    output logic              valid_c
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx_c   = IDX_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list lowest-first, one word access per set bit,
// with optional base writeback.
module ldm_stm_sequencer
    import arm_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic [LIST_W-1:0] reg_list,
    input  logic [REG_W-1:0]  base_reg,
    input  logic [ADDR_W-1:0] base_val,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    output logic [REG_W-1:0]  read_reg_num,
    input  logic [ADDR_W-1:0] read_data,
    output logic [REG_W-1:0]  write_reg,
    output logic [ADDR_W-1:0] write_data,
    output logic              regwrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pc_loaded
);

    seq_state_t        state_q, state_d;
    logic [LIST_W-1:0] list_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] final_q;
    xfer_ctx_t         ctx_q;

    logic [IDX_W-1:0]  cur_idx_c;
    logic              cur_valid_c;
    logic [LIST_W-1:0] list_rem_c;
    logic [CNT_W-1:0]  n_c;
    logic [ADDR_W-1:0] span_c;
    logic [ADDR_W-1:0] start_addr_c;
    logic [ADDR_W-1:0] final_c;
    logic              wb_en_c;
    logic              has_pc_c;

    lowest_set_bit u_lsb (
        .bits    (list_q),
        .idx_c   (cur_idx_c),
        .valid_c (cur_valid_c)
    );

    assign list_rem_c = list_q & ~(LIST_W'(1) << cur_idx_c);
    assign mem_wdata  = read_data;

    // Popcount of the incoming list; sized to hold 16.
    always_comb begin
        n_c = '0;
        for (int i = 0; i < LIST_W; i++) begin
            n_c = n_c + CNT_W'(reg_list[i]);
        end
    end

    // Start address and final base, computed from the live inputs at start time.
    always_comb begin
        span_c = ADDR_W'(n_c) * ADDR_W'(WORD_BYTES);
        unique case (decode_mode(pre, up))
            MODE_IA: start_addr_c = base_val;
            MODE_IB: start_addr_c = base_val + ADDR_W'(WORD_BYTES);
            MODE_DA: start_addr_c = base_val - span_c + ADDR_W'(WORD_BYTES);
            MODE_DB: start_addr_c = base_val - span_c;
            default: start_addr_c = base_val;
        endcase
        final_c  = up ? (base_val + span_c) : (base_val - span_c);
        // A loaded base register beats the writeback value.
        wb_en_c  = wback && (n_c != '0) && !(is_load && reg_list[base_reg[IDX_W-1:0]]);
        has_pc_c = is_load && reg_list[REG_PC];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transfer context and running address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            list_q  <= '0;
            addr_q  <= '0;
            final_q <= '0;
            ctx_q   <= '0;
        end else if (state_q == ST_IDLE && start) begin
            list_q  <= reg_list;
            addr_q  <= start_addr_c;
            final_q <= final_c;
            ctx_q   <= '{is_load: is_load, wb_en: wb_en_c, has_pc: has_pc_c, base_reg: base_reg};
        end else if (state_q == ST_XFER && mem_ack) begin
            list_q  <= list_rem_c;
            addr_q  <= addr_q + ADDR_W'(WORD_BYTES);
        end
    end

    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        done         = 1'b0;
        pc_loaded    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        read_reg_num = '0;
        regwrite     = 1'b0;
        write_reg    = '0;
        write_data   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n_c == '0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = !ctx_q.is_load;
                mem_addr = addr_q;
                if (!ctx_q.is_load) begin
                    read_reg_num = REG_W'(cur_idx_c);
                end
                if (mem_ack && cur_valid_c) begin
                    if (ctx_q.is_load) begin
                        regwrite   = 1'b1;
                        write_reg  = REG_W'(cur_idx_c);
                        write_data = mem_rdata;
                    end
                    if (list_rem_c == '0) begin
                        state_d = ctx_q.wb_en ? ST_WB : ST_DONE;
                    end
                end
            end
            ST_WB: begin
                busy       = 1'b1;
                regwrite   = 1'b1;
                write_reg  = ctx_q.base_reg;
                write_data = final_q;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                pc_loaded = ctx_q.has_pc;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: a per-cycle expected trace built from the
// transfer rules, plus literal checks on a few well-known sequences.
module tb_ldm_stm_sequencer;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic [15:0] reg_list;
    logic [4:0]  base_reg;
    logic [31:0] base_val;
    logic        up, pre, wback;
    logic [4:0]  read_reg_num;
    logic [31:0] read_data;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        regwrite, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy, done, pc_loaded;

    ldm_stm_sequencer #(.ADDR_W(32)) dut (
        .clock(clock), .reset(rst_n), .start(start), .is_load(is_load),
        .reg_list(reg_list), .base_reg(base_reg), .base_val(base_val),
        .up(up), .pre(pre), .wback(wback),
        .read_reg_num(read_reg_num), .read_data(read_data),
        .write_reg(write_reg), .write_data(write_data), .regwrite(regwrite),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pc_loaded(pc_loaded)
    );

    always #5 clock = ~clock;

    logic [31:0] rf [16];
    assign read_data = rf[read_reg_num[3:0]];

    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
        logic        busy;
        logic        done;
        logic        pc;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [4:0]  rnum;
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } cyc_t;

    cyc_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;
    int          done_cyc;
    int          rw_cnt;
    int          req_cnt;
    logic        pc_seen;
    logic [31:0] last_wb;
    logic [31:0] addr_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Expected trace: one record per cycle after start, derived from the transfer rules.
    task automatic build(input bit ld, input logic [15:0] lst, input logic [4:0] br,
                         input logic [31:0] bv, input bit u, input bit p, input bit wb,
                         input int wt, input logic [31:0] rseed);
        int          n;
        int          k;
        logic [31:0] a;
        logic [31:0] fin;
        cyc_t        c;
        n   = $countones(lst);
        k   = 0;
        fin = u ? bv + 32'(4 * n) : bv - 32'(4 * n);
        if (u) a = p ? bv + 32'd4 : bv;
        else   a = p ? bv - 32'(4 * n) : bv - 32'(4 * n) + 32'd4;
        for (int r = 0; r < 16; r++) begin
            if (lst[r]) begin
                for (int w = 0; w <= wt; w++) begin
                    c       = '0;
                    c.busy  = 1'b1;
                    c.req   = 1'b1;
                    c.we    = !ld;
                    c.addr  = a;
                    c.rnum  = 5'(r);
                    c.ack   = (w == wt);
                    c.rdata = c.ack ? rseed + 32'(k * 17) : 32'hDEAD_BEEF;
                    if (ld && c.ack) begin
                        c.rw    = 1'b1;
                        c.wreg  = 5'(r);
                        c.wdata = c.rdata;
                    end
                    q.push_back(c);
                end
                a = a + 32'd4;
                k++;
            end
        end
        if (wb && n > 0 && !(ld && lst[br[3:0]])) begin
            c       = '0;
            c.busy  = 1'b1;
            c.rw    = 1'b1;
            c.wreg  = br;
            c.wdata = fin;
            q.push_back(c);
        end
        c      = '0;
        c.busy = 1'b1;
        c.done = 1'b1;
        c.pc   = ld && lst[15];
        q.push_back(c);
    endtask

    // One clock: drive this cycle's memory response after the edge, check at the falling edge.
    task automatic step(input bit poke);
        cyc_t e;
        @(posedge clock);
        #1;
        start = poke;
        if (poke) begin
            reg_list = 16'hFFFF;
            is_load  = ~is_load;
            base_val = 32'h5555_0000;
        end
        cyc++;
        e = (q.size() > 0) ? q.pop_front() : '0;
        mem_ack   = e.ack;
        mem_rdata = e.rdata;
        @(negedge clock);
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("pc_loaded", 32'(pc_loaded), 32'(e.pc));
        chk("mem_req", 32'(mem_req), 32'(e.req));
        chk("regwrite", 32'(regwrite), 32'(e.rw));
        if (e.req) begin
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) begin
                chk("read_reg_num", 32'(read_reg_num), 32'(e.rnum));
                chk("mem_wdata", mem_wdata, rf[e.rnum[3:0]]);
            end
        end
        if (e.rw) begin
            chk("write_reg", 32'(write_reg), 32'(e.wreg));
            chk("write_data", write_data, e.wdata);
        end
        if (done) done_cyc = cyc;
        if (regwrite) rw_cnt++;
        if (regwrite && !mem_req) last_wb = write_data;
        if (mem_req) req_cnt++;
        if (mem_req && mem_ack) addr_log.push_back(mem_addr);
        if (pc_loaded) pc_seen = 1'b1;
    endtask

    task automatic begin_txn(input bit ld, input logic [15:0] lst, input logic [4:0] br,
                             input logic [31:0] bv, input bit u, input bit p, input bit wb,
                             input int wt, input logic [31:0] rseed);
        is_load  = ld;
        reg_list = lst;
        base_reg = br;
        base_val = bv;
        up       = u;
        pre      = p;
        wback    = wb;
        start    = 1'b1;
        q.delete();
        build(ld, lst, br, bv, u, p, wb, wt, rseed);
        cyc      = 0;
        done_cyc = -1;
        rw_cnt   = 0;
        req_cnt  = 0;
        pc_seen  = 1'b0;
        last_wb  = 32'hFFFF_FFFF;
        addr_log.delete();
    endtask

    task automatic run_txn(input bit ld, input logic [15:0] lst, input logic [4:0] br,
                           input logic [31:0] bv, input bit u, input bit p, input bit wb,
                           input int wt, input logic [31:0] rseed, input int poke_at);
        int s;
        begin_txn(ld, lst, br, bv, u, p, wb, wt, rseed);
        s = 0;
        while (q.size() > 0) begin
            step(s == poke_at);
            s++;
        end
        step(1'b0);
        step(1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_regwrite"}, 32'(regwrite), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_pc_loaded"}, 32'(pc_loaded), 32'd0);
        chk({tag, "_read_reg_num"}, 32'(read_reg_num), 32'd0);
        chk({tag, "_write_reg"}, 32'(write_reg), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_write_data"}, write_data, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'hC0DE_0000 + 32'(i * 32'h101);
        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; reg_list = '0; base_reg = '0;
        base_val = '0; up = 1'b0; pre = 1'b0; wback = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        cyc = 0;
        repeat (2) @(negedge clock);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        step(1'b0);

        // STM IA r1..r3, writeback.
        run_txn(1'b0, 16'h000E, 5'd13, 32'h1000, 1'b1, 1'b0, 1'b1, 0, 32'h0, -1);
        chk("stm_ia_done_cycle", 32'(done_cyc), 32'd5);
        chk("stm_ia_acks", 32'(addr_log.size()), 32'd3);
        chk("stm_ia_addr0", addr_log[0], 32'h1000);
        chk("stm_ia_addr2", addr_log[2], 32'h1008);
        chk("stm_ia_wb", last_wb, 32'h100C);

        // LDM DB r0, r15, no writeback.
        run_txn(1'b1, 16'h8001, 5'd13, 32'h2000, 1'b0, 1'b1, 1'b0, 0, 32'hAA, -1);
        chk("ldm_db_addr0", addr_log[0], 32'h1FF8);
        chk("ldm_db_addr1", addr_log[1], 32'h1FFC);
        chk("ldm_db_pc_loaded", 32'(pc_seen), 32'd1);
        chk("ldm_db_regwrites", 32'(rw_cnt), 32'd2);

        // LDM IA with base in list: loaded value wins, no WB cycle.
        run_txn(1'b1, 16'h0004, 5'd2, 32'h3000, 1'b1, 1'b0, 1'b1, 0, 32'h1234_5678, -1);
        chk("ldm_base_regwrites", 32'(rw_cnt), 32'd1);
        chk("ldm_base_done_cycle", 32'(done_cyc), 32'd2);

        // Empty list.
        run_txn(1'b0, 16'h0000, 5'd3, 32'h7000, 1'b1, 1'b0, 1'b1, 0, 32'h0, -1);
        chk("empty_done_cycle", 32'(done_cyc), 32'd1);
        chk("empty_reqs", 32'(req_cnt), 32'd0);
        chk("empty_regwrites", 32'(rw_cnt), 32'd0);

        // STM IB with 3 wait cycles per access and a start pulse while busy.
        run_txn(1'b0, 16'h00A5, 5'd9, 32'h4000, 1'b1, 1'b1, 1'b1, 3, 32'h0, 3);
        chk("wait_done_cycle", 32'(done_cyc), 32'd18);
        chk("wait_addr0", addr_log[0], 32'h4004);
        chk("wait_wb", last_wb, 32'h4010);

        // LDM DA and STM DB wrapping below zero.
        run_txn(1'b1, 16'h0300, 5'd0, 32'h10, 1'b0, 1'b0, 1'b1, 1, 32'h77, -1);
        run_txn(1'b0, 16'h0003, 5'd5, 32'h4, 1'b0, 1'b1, 1'b1, 0, 32'h0, -1);
        chk("wrap_addr0", addr_log[0], 32'hFFFF_FFFC);
        chk("wrap_wb", last_wb, 32'hFFFF_FFFC);

        // STM with base in list still writes back.
        run_txn(1'b0, 16'h0006, 5'd1, 32'h800, 1'b1, 1'b0, 1'b1, 0, 32'h0, -1);
        chk("stm_base_wb", last_wb, 32'h808);

        // Reset mid-transfer after the first of four acks.
        begin_txn(1'b0, 16'h000F, 5'd13, 32'h6000, 1'b1, 1'b0, 1'b1, 0, 32'h0);
        step(1'b0);
        @(posedge clock);
        #1;
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk_reset_outputs("abort");
        q.delete();
        @(negedge clock);
        chk_reset_outputs("abort_hold");
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        step(1'b0);
        run_txn(1'b1, 16'h0003, 5'd4, 32'h9000, 1'b1, 1'b0, 1'b1, 0, 32'h40, -1);
        chk("post_reset_done_cycle", 32'(done_cyc), 32'd4);
        chk("post_reset_wb", last_wb, 32'h9008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-register transfer sequencer for LDM/STM instructions. It walks a 16-bit register list, lowest register first, and issues one word memory access per set bit. For stores it drives the register-file read port; for loads it drives the register-file write port. It optionally writes back the updated base address, sitting directly between decode and the register file and memory interface.

## Interface
Parameters:
- `ADDR_W`, 32, address and data width.

Ports:
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  accept a new transfer; honoured only when `busy`=0.
- `is_load`  in  1  1=LDM, 0=STM.
- `reg_list`  in  16  register list, bit i = r_i.
- `base_reg`  in  5  base register number (0–15).
- `base_val`  in  32  current base register contents.
- `up`, `pre`, `wback`  in  1 each  U, P and W bits.
- `read_reg_num`  out  5  register-file read select (STM data).
- `read_data`  in  32  register-file read data, combinational.
- `write_reg`  out  5  register-file write select.
- `write_data`  out  32  register-file write data.
- `regwrite`  out  1  register-file write enable.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  1=write.
- `mem_addr`  out  32  word address.
- `mem_wdata`  out  32  store data (= `read_data`).
- `mem_ack`  in  1  access complete this cycle.
- `mem_rdata`  in  32  load data, valid with `mem_ack`.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `pc_loaded`  out  1  one-cycle pulse when r15 was loaded.

## Operation
- States: IDLE, XFER, WB, DONE.
- **Start.** `start` in IDLE latches `reg_list`, `is_load`, `base_reg` and `wback`.
  - It also latches n = popcount(list) and the start address.
  - Start address per mode: IA = base; IB = base+4; DA = base−4n+4; DB = base−4n.
  - Final base value: base ± 4n.
- **Empty list** (n=0): IDLE→DONE, no memory access, no writeback.
- **XFER.** The current register is the lowest set bit of the remaining list.
  - `mem_req`=1, `mem_addr` = running address.
  - STM: `read_reg_num` = current register.
  - On `mem_ack`: clear that bit and add 4 to the address.
  - Load: `regwrite`=1 in the `mem_ack` cycle, with `write_reg` = current register and `write_data` = `mem_rdata`.
  - When the list becomes empty: go to WB if `wback`, else DONE.
- **WB.** One cycle: `regwrite`=1, `write_reg` = base, `write_data` = final base value.
  - Suppressed (WB skipped) when `is_load` and the base register is in the list; the loaded value wins.
- **DONE.** `done`=1 for one cycle, then IDLE.
  - `pc_loaded`=1 in the DONE cycle if the list included r15 and `is_load`.
- `busy`=1 in XFER, WB and DONE.
- `start` while `busy`: ignored.
- Address arithmetic is modulo 2^32; wrap is silent.
- STM with the base register in the list stores the original base value (writeback happens after all stores).

## Timing
- Reset values: state IDLE; `busy`, `done`, `regwrite`, `mem_req`, `mem_we`, `pc_loaded` = 0; `read_reg_num`, `write_reg` = 0; `mem_addr`, `write_data` = 0.
- Reset mid-sequence aborts immediately; no further regwrite or request is issued.
- Cycle timing for `start` at cycle 0:
  - First `mem_req` in cycle 1.
  - With zero-wait `mem_ack`, n transfers occupy cycles 1..n.
  - WB occurs in cycle n+1 and `done` in n+2 (n+1 without writeback).
- Each wait cycle (`mem_req`=1, `mem_ack`=0) holds all outputs stable.
- `regwrite` and `mem_req` are never both driven for WB and a transfer in the same cycle.

## Structure
- Shared package `arm_pkg`:
  - state enum `seq_state_t`;
  - constants `WORD_BYTES`=4 and `REG_PC`=15;
  - addressing-mode encoding {IA, IB, DA, DB} derived from P/U.
- Sub-module `lowest_set_bit`: 16-bit combinational priority encoder giving a 4-bit index and a valid flag.
- Popcount is done inline in the sequencer.

## Test plan
- **STM IA:** list=0x000E, base=0x1000, wback=1, zero-wait.
  - Writes r1,r2,r3 to 0x1000, 0x1004, 0x1008.
  - WB r_base=0x100C; `done` at cycle 5.
- **LDM DB:** list=0x8001, base=0x2000, rdata=0xAA, 0xBB.
  - Loads r0←0xAA @0x1FF8 and r15←0xBB @0x1FFC.
  - `pc_loaded` pulses; no WB since wback=0.
- **LDM IA with base in list:** base=r2, list=0x0004, wback=1.
  - r2←loaded data and no WB cycle.
- **Empty list:** `start` → `done` at cycle 1.
  - No `mem_req`, no `regwrite`.
- **Wait states:** `mem_ack` delayed 3 cycles on each access.
  - `mem_addr` and `read_reg_num` are stable while waiting.
  - Total latency grows by 3 per transfer.
- **Reset mid-XFER:** assert `reset`=0 after the 1st of 4 acks.
  - All outputs return to reset values immediately.
  - A new `start` after release runs cleanly.
